mux_nx1_scan: RTL and testbench

//  Parametrised N-to-1, W-bit multiplexer built from a one-hot channel decoder
//  and AND-gated enables, with a registered valid/ready output stage.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/onehot_decoder.sv | 14 +
 rtl/mux_nx1_scan.sv | 100 ++++++++++
 tb/tb_mux_nx1_scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the N-to-1 scanning multiplexer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Channel index to one-hot enable vector; out-of-range indices give all zeros.
module onehot_decoder #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [SELW-1:0] idx,
    output logic [N-1:0]    onehot
);

    for (genvar k = 0; k < N; k++) begin : g_bit
        assign onehot[k] = (idx == SELW'(k));
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-to-1 W-bit AND/OR multiplexer with manual or round-robin scan channel
// selection and a one-entry valid/ready output register.
module mux_nx1_scan
    import mux_scan_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic            sel_load,
    input  logic [N*W-1:0]  in_bus,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] ch,
    output logic            err
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t              state, state_nxt;
    logic [SELW-1:0]     cur_ch;
    logic [DCW-1:0]      dwell_cnt;
    logic [N-1:0]        en_vec;
    logic [N-1:0][W-1:0] gated;
    logic [W-1:0]        y_next;
    logic                run, ld, man_load, sel_ok, dwell_end;

    onehot_decoder #(.N(N)) u_dec (
        .idx    (cur_ch),
        .onehot (en_vec)
    );

    for (genvar k = 0; k < N; k++) begin : g_gate
        assign gated[k] = in_bus[k*W +: W] & {W{en_vec[k]}};
    end

    always_comb begin
        y_next = '0;
        for (int k = 0; k < N; k++) y_next |= gated[k];
    end

    always_comb begin
        state_nxt = ST_IDLE;
        if (en) state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    end

    assign run       = (state != ST_IDLE);
    assign ld        = run & (~out_valid | out_ready);
    assign man_load  = sel_load & (mode == MODE_MANUAL);
    assign sel_ok    = (int'(sel) < N);
    assign dwell_end = (dwell_cnt == DCW'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A manual load on the same edge as a scan step wins the channel update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (state == ST_SCAN && ld) begin
                if (dwell_end) begin
                    dwell_cnt <= '0;
                    cur_ch    <= (cur_ch == SELW'(N - 1)) ? '0 : cur_ch + 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
            if (state_nxt == ST_SCAN && state != ST_SCAN) dwell_cnt <= '0;
            if (man_load && sel_ok)  cur_ch <= sel;
            if (man_load && !sel_ok) err    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            ch        <= '0;
        end else if (ld) begin
            out_valid <= 1'b1;
            y         <= y_next;
            ch        <= cur_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Scoreboard bench: a transaction-level model predicts every loaded sample,
// a monitor pops and compares on each output handshake.
module tb_mux_nx1_scan;

    localparam int W     = 8;
    localparam int N     = 5;
    localparam int DWELL = 2;
    localparam int SELW  = $clog2(N);

    logic            clk = 1'b0;
    logic            rst, en, mode, sel_load, out_ready;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  in_bus;
    logic            out_valid, err;
    logic [W-1:0]    y;
    logic [SELW-1:0] ch;

    mux_nx1_scan #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .sel_load  (sel_load),
        .in_bus    (in_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y         (y),
        .ch        (ch),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int c; int d; } smp_t;
    smp_t q[$];

    // Model: 0 idle, 1 manual, 2 scan; counts accepted samples per channel.
    int m_state, m_ch, m_cnt;
    bit m_valid, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_ch = 0; m_cnt = 0; m_valid = 0; m_err = 0;
            q.delete();
        end else begin
            bit   ld;
            int   nxt;
            smp_t s;
            ld = (m_state != 0) && (!m_valid || out_ready);
            if (ld) begin
                s.c = m_ch;
                s.d = int'(in_bus[m_ch*W +: W]);
                q.push_back(s);
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (m_state == 2 && ld) begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_cnt = 0;
                    m_ch  = (m_ch + 1) % N;
                end
            end
            if (sel_load && !mode) begin
                if (int'(sel) < N) m_ch = int'(sel);
                else               m_err = 1;
            end
            nxt = !en ? 0 : (mode ? 2 : 1);
            if (nxt == 2 && m_state != 2) m_cnt = 0;
            m_state = nxt;
        end
    end

    bit              hold_prev = 0;
    logic [W-1:0]    py;
    logic [SELW-1:0] pch;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 0;
        end else begin
            smp_t s;
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("err", 32'(err), 32'(m_err));
            if (hold_prev) begin
                chk("hold_y", 32'(y), 32'(py));
                chk("hold_ch", 32'(ch), 32'(pch));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty got ch=%0d y=%0h want no sample at %0t", ch, y, $time);
                end else begin
                    s = q.pop_front();
                    chk("sb_ch", 32'(ch), 32'(s.c));
                    chk("sb_y", 32'(y), 32'(s.d));
                end
            end
            hold_prev = out_valid && !out_ready;
            py  = y;
            pch = ch;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; sel = '0; sel_load = 0; out_ready = 1;
        in_bus = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
        step(2);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_ch", 32'(ch), 0);
        chk("rst_err", 32'(err), 0);
        rst = 0;
        step(1);

        // Manual load of channel 2
        en = 1; mode = 0; sel = 3'd2; sel_load = 1;
        step(1);
        sel_load = 0;
        step(1);
        chk("man_y", 32'(y), 32'h C2);
        chk("man_ch", 32'(ch), 2);

        // Backpressure: held sample, then new data right after acceptance
        out_ready = 0;
        step(5);
        chk("bp_y", 32'(y), 32'h C2);
        chk("bp_ch", 32'(ch), 2);
        in_bus[2*W +: W] = 8'h5A;
        step(1);
        out_ready = 1;
        step(1);
        chk("bp_new_y", 32'(y), 32'h5A);

        // Scan with an ignored out-of-range sel_load
        sel = 3'd0; sel_load = 1;
        step(1);
        mode = 1; sel = 3'd7;
        step(1);
        sel_load = 0;
        step(14);
        chk("scan_err", 32'(err), 0);

        // Out-of-range manual load sets sticky err
        mode = 0; sel = 3'd5; sel_load = 1;
        step(1);
        sel_load = 0;
        chk("err_set", 32'(err), 1);
        sel = 3'd1; sel_load = 1;
        step(1);
        sel_load = 0;
        step(1);
        chk("err_sticky", 32'(err), 1);
        chk("err_ch", 32'(ch), 1);

        // en drop with held sample
        out_ready = 0;
        step(2);
        en = 0;
        step(3);
        chk("endrop_hold", 32'(out_valid), 1);
        out_ready = 1;
        step(1);
        chk("endrop_drain", 32'(out_valid), 0);
        step(3);
        chk("endrop_idle", 32'(out_valid), 0);

        // Reset mid-transfer
        en = 1; out_ready = 0;
        step(2);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_y", 32'(y), 0);
        chk("mid_rst_ch", 32'(ch), 0);
        chk("mid_rst_err", 32'(err), 0);
        step(1);
        rst = 0; mode = 0; out_ready = 1;
        step(2);
        chk("post_rst_ch", 32'(ch), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom % 8) != 0;
            if (($urandom % 16) == 0) mode = ~mode;
            sel_load  = ($urandom % 6) == 0;
            sel       = SELW'($urandom % 8);
            out_ready = ($urandom % 3) != 0;
            for (int k = 0; k < N; k++) in_bus[k*W +: W] = W'($urandom);
            step(1);
        end

        en = 0; sel_load = 0; out_ready = 1;
        step(5);
        chk("sb_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
